// File: rtl/display_timing_gen.sv
// Raster timing generator: free-running sx/sy counters, combinational strobes,
// and a LAT-deep alignment line so de/syncs/colour reach the TMDS stage together.
module display_timing_gen #(
   parameter int H_RES  = 640,
   parameter int H_FP   = 16,
   parameter int H_SYNC = 96,
   parameter int H_BP   = 48,
   parameter int V_RES  = 480,
   parameter int V_FP   = 10,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 33,
   parameter int H_POL  = 0,
   parameter int V_POL  = 0,
   parameter int LAT    = 2,
   parameter int CORDW  = 16
) (
   input  logic             clk_pix,
   input  logic             rst_pix,
   output logic [CORDW-1:0] sx,
   output logic [CORDW-1:0] sy,
   output logic             line,
   output logic             frame,
   input  logic [7:0]       r_in,
   input  logic [7:0]       g_in,
   input  logic [7:0]       b_in,
   output logic [7:0]       red,
   output logic [7:0]       green,
   output logic [7:0]       blue,
   output logic             de,
   output logic             hsync,
   output logic             vsync
);
   localparam int H_TOT = H_RES + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_RES + V_FP + V_SYNC + V_BP;

   localparam logic [CORDW-1:0] H_MAX  = CORDW'(H_TOT - 1);
   localparam logic [CORDW-1:0] V_MAX  = CORDW'(V_TOT - 1);
   localparam logic [CORDW-1:0] H_ACT  = CORDW'(H_RES);
   localparam logic [CORDW-1:0] V_ACT  = CORDW'(V_RES);
   localparam logic [CORDW-1:0] HS_BEG = CORDW'(H_RES + H_FP);
   localparam logic [CORDW-1:0] HS_END = CORDW'(H_RES + H_FP + H_SYNC);
   localparam logic [CORDW-1:0] VS_BEG = CORDW'(V_RES + V_FP);
   localparam logic [CORDW-1:0] VS_END = CORDW'(V_RES + V_FP + V_SYNC);
   localparam logic             HS_ON  = (H_POL != 0);
   localparam logic             VS_ON  = (V_POL != 0);

   logic [CORDW-1:0] r_sx;
   logic [CORDW-1:0] r_sy;
   logic             w_de_raw;
   logic             w_hs_raw;
   logic             w_vs_raw;
   logic [2:0]       w_raw;
   logic [2:0]       w_dly;
   logic [7:0]       r_red;
   logic [7:0]       r_green;
   logic [7:0]       r_blue;
   logic             r_de;
   logic             r_hsync;
   logic             r_vsync;

   always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
         r_sx <= '0;
         r_sy <= '0;
      end else if (r_sx == H_MAX) begin
         r_sx <= '0;
         r_sy <= (r_sy == V_MAX) ? '0 : r_sy + CORDW'(1);
      end else begin
         r_sx <= r_sx + CORDW'(1);
      end
   end

   assign w_de_raw = (r_sx < H_ACT) && (r_sy < V_ACT);
   assign w_hs_raw = (r_sx >= HS_BEG) && (r_sx < HS_END);
   assign w_vs_raw = (r_sy >= VS_BEG) && (r_sy < VS_END);
   assign w_raw    = {w_de_raw, w_hs_raw, w_vs_raw};

   // Delay line carries active-flags, not pin levels, so reset loads plain zeros.
   generate
      if (LAT == 0) begin : g_no_dly
         assign w_dly = w_raw;
      end else begin : g_dly
         logic [2:0] r_pipe [LAT];
         always_ff @(posedge clk_pix) begin
            if (rst_pix) begin
               for (int i = 0; i < LAT; i++) r_pipe[i] <= 3'b000;
            end else begin
               r_pipe[0] <= w_raw;
               for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
            end
         end
         assign w_dly = r_pipe[LAT-1];
      end
   endgenerate

   always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
         r_red   <= 8'h00;
         r_green <= 8'h00;
         r_blue  <= 8'h00;
         r_de    <= 1'b0;
         r_hsync <= ~HS_ON;
         r_vsync <= ~VS_ON;
      end else begin
         r_red   <= w_dly[2] ? r_in : 8'h00;
         r_green <= w_dly[2] ? g_in : 8'h00;
         r_blue  <= w_dly[2] ? b_in : 8'h00;
         r_de    <= w_dly[2];
         r_hsync <= w_dly[1] ? HS_ON : ~HS_ON;
         r_vsync <= w_dly[0] ? VS_ON : ~VS_ON;
      end
   end

   assign sx    = r_sx;
   assign sy    = r_sy;
   assign line  = (r_sx == '0);
   assign frame = (r_sx == '0) && (r_sy == '0);
   assign red   = r_red;
   assign green = r_green;
   assign blue  = r_blue;
   assign de    = r_de;
   assign hsync = r_hsync;
   assign vsync = r_vsync;

endmodule

// File: tb/tb_display_timing_gen.sv
// Four timing generators (default, two reduced-size LAT variants, active-high syncs)
// checked every cycle against an arithmetic raster model plus run/period statistics.
module tb_display_timing_gen;
   localparam int NI = 4;
   localparam int P_HR  [NI] = '{640, 40, 40, 16};
   localparam int P_HF  [NI] = '{16,  4,  4,  1};
   localparam int P_HS  [NI] = '{96,  6,  6,  2};
   localparam int P_HB  [NI] = '{48,  6,  6,  1};
   localparam int P_VR  [NI] = '{480, 24, 24, 8};
   localparam int P_VF  [NI] = '{10,  2,  2,  1};
   localparam int P_VS  [NI] = '{2,   3,  3,  2};
   localparam int P_VB  [NI] = '{33,  3,  3,  1};
   localparam int P_HP  [NI] = '{0,   0,  0,  1};
   localparam int P_VP  [NI] = '{0,   0,  0,  1};
   localparam int P_LAT [NI] = '{2,   2,  0,  3};

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n = 0;
   int   checks = 0;
   int   errors = 0;

   logic [15:0] sx_o [NI];
   logic [15:0] sy_o [NI];
   logic        line_o [NI], frame_o [NI], de_o [NI], hs_o [NI], vs_o [NI];
   logic [7:0]  red_o [NI], grn_o [NI], blu_o [NI];
   logic [7:0]  r_i [NI], g_i [NI], b_i [NI];

   int run_len [5];
   bit run_ok  [5];
   int gap_cnt [4];
   bit gap_ok  [4];
   int de_acc;

   always #5 clk = ~clk;

   // Cycles since the last reset edge; the whole model is derived from this.
   always @(posedge clk) n <= rst ? 0 : n + 1;

   generate
      for (genvar gi = 0; gi < NI; gi++) begin : g_dut
         display_timing_gen #(
            .H_RES(P_HR[gi]), .H_FP(P_HF[gi]), .H_SYNC(P_HS[gi]), .H_BP(P_HB[gi]),
            .V_RES(P_VR[gi]), .V_FP(P_VF[gi]), .V_SYNC(P_VS[gi]), .V_BP(P_VB[gi]),
            .H_POL(P_HP[gi]), .V_POL(P_VP[gi]), .LAT(P_LAT[gi]), .CORDW(16)
         ) u_dut (
            .clk_pix(clk), .rst_pix(rst),
            .sx(sx_o[gi]), .sy(sy_o[gi]), .line(line_o[gi]), .frame(frame_o[gi]),
            .r_in(r_i[gi]), .g_in(g_i[gi]), .b_in(b_i[gi]),
            .red(red_o[gi]), .green(grn_o[gi]), .blue(blu_o[gi]),
            .de(de_o[gi]), .hsync(hs_o[gi]), .vsync(vs_o[gi])
         );
      end
   endgenerate

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model(input int k, input int cnt, input logic [7:0] b_last);
      int ht = P_HR[k] + P_HF[k] + P_HS[k] + P_HB[k];
      int vt = P_VR[k] + P_VF[k] + P_VS[k] + P_VB[k];
      int cx = cnt % ht;
      int cy = (cnt / ht) % vt;
      int px = 0, py = 0;
      logic d = 1'b0, ha = 1'b0, va = 1'b0;
      logic hsl, vsl;
      logic [7:0] rr, gg, bb;
      if (cnt >= P_LAT[k] + 1) begin
         px = (cnt - P_LAT[k] - 1) % ht;
         py = ((cnt - P_LAT[k] - 1) / ht) % vt;
         d  = (px < P_HR[k]) && (py < P_VR[k]);
         ha = (px >= P_HR[k] + P_HF[k]) && (px < P_HR[k] + P_HF[k] + P_HS[k]);
         va = (py >= P_VR[k] + P_VF[k]) && (py < P_VR[k] + P_VF[k] + P_VS[k]);
      end
      hsl = ha ? (P_HP[k] != 0) : (P_HP[k] == 0);
      vsl = va ? (P_VP[k] != 0) : (P_VP[k] == 0);
      rr = d ? 8'(px) : 8'h00;
      gg = d ? 8'(py) : 8'h00;
      bb = d ? b_last : 8'h00;
      return {3'b000, 16'(cx), 16'(cy), (cx == 0), (cx == 0) && (cy == 0), d, hsl, vsl, rr, gg, bb};
   endfunction

   task automatic run_trk(input int k, input string tag, input logic act, input int want);
      if (act) run_len[k]++;
      else begin
         if (run_ok[k] && run_len[k] > 0) chk(tag, 64'(run_len[k]), 64'(want));
         run_ok[k]  = 1'b1;
         run_len[k] = 0;
      end
   endtask

   task automatic gap_trk(input int k, input string tag, input logic strobe, input int want);
      gap_cnt[k]++;
      if (strobe) begin
         if (gap_ok[k]) chk(tag, 64'(gap_cnt[k]), 64'(want));
         gap_ok[k]  = 1'b1;
         gap_cnt[k] = 0;
      end
   endtask

   task automatic clear_trk();
      for (int i = 0; i < 5; i++) begin run_len[i] = 0; run_ok[i] = 1'b0; end
      for (int i = 0; i < 4; i++) begin gap_cnt[i] = 0; gap_ok[i] = 1'b0; end
      de_acc = 0;
   endtask

   initial begin
      int mid, ncyc, ht, vt, p;
      logic [63:0] obs;
      for (int k = 0; k < NI; k++) begin r_i[k] = 8'h00; g_i[k] = 8'h00; b_i[k] = 8'h00; end
      clear_trk();
      mid  = 2000 + $urandom_range(0, 1000);
      ncyc = mid + 3 + 2 * 1792 + 300;
      repeat (3) @(posedge clk);
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         for (int k = 0; k < NI; k++) begin
            obs = {3'b000, sx_o[k], sy_o[k], line_o[k], frame_o[k], de_o[k], hs_o[k], vs_o[k],
                   red_o[k], grn_o[k], blu_o[k]};
            chk($sformatf("pix%0d n=%0d", k, n), obs, model(k, n, b_i[k]));
         end
         if (rst) clear_trk();
         else begin
            run_trk(0, "def_hsync_width", hs_o[0] == 1'b0, 96);
            run_trk(1, "def_de_run", de_o[0], 640);
            run_trk(2, "c_hsync_width", hs_o[3] == 1'b1, 2);
            run_trk(3, "c_vsync_width", vs_o[3] == 1'b1, 40);
            run_trk(4, "a_vsync_width", vs_o[1] == 1'b0, 168);
            gap_trk(0, "def_line_period", line_o[0], 800);
            if (frame_o[1]) begin
               if (gap_ok[1]) chk("a_de_per_frame", 64'(de_acc), 64'd960);
               de_acc = 0;
            end
            de_acc += int'(de_o[1]);
            gap_trk(1, "a_frame_period", frame_o[1], 1792);
            gap_trk(2, "c_line_period", line_o[3], 20);
            gap_trk(3, "c_frame_period", frame_o[3], 240);
         end
         rst = (c >= mid) && (c < mid + 3);
         // Colour source model: coordinates of the pixel issued LAT cycles ago.
         for (int k = 0; k < NI; k++) begin
            ht = P_HR[k] + P_HF[k] + P_HS[k] + P_HB[k];
            vt = P_VR[k] + P_VF[k] + P_VS[k] + P_VB[k];
            if (n >= P_LAT[k]) begin
               p = n - P_LAT[k];
               r_i[k] = 8'(p % ht);
               g_i[k] = 8'((p / ht) % vt);
            end else begin
               r_i[k] = 8'h00;
               g_i[k] = 8'h00;
            end
            b_i[k] = 8'($urandom);
         end
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/display_timing_gen.md
# display_timing_gen

Pixel-clock display timing generator and colour alignment stage. It produces raster coordinates for the pixel source and accepts that source's colour LAT cycles later. It then emits registered RGB, de, hsync and vsync with matching alignment, ready for the TMDS/GPDI output stage. It sits directly upstream of the HDMI serializer and is its only source of sync and data-enable.

## Interface
Parameters:
- H_RES, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_RES, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync active level (0 = active-low)
- V_POL, 0, vsync active level (0 = active-low)
- LAT, 2, pixel-source latency in cycles from coordinates to r_in/g_in/b_in; range 0..15
- CORDW, 16, coordinate width

Ports:
- clk_pix  in  1  pixel clock; all logic on rising edge
- rst_pix  in  1  synchronous reset, active-high
- sx  out  CORDW  current horizontal counter
- sy  out  CORDW  current vertical counter
- line  out  1  one-cycle strobe at sx==0
- frame  out  1  one-cycle strobe at sx==0 && sy==0
- r_in, g_in, b_in  in  8 each  colour for the coordinates issued LAT cycles earlier
- red, green, blue  out  8 each  aligned colour to the output stage
- de  out  1  aligned data enable
- hsync, vsync  out  1 each  aligned syncs at configured polarity

## Operation
- H_TOT = H_RES+H_FP+H_SYNC+H_BP (800 by default); V_TOT = V_RES+V_FP+V_SYNC+V_BP (525 by default).
- Horizontal counter sx:
  - counts 0..H_TOT-1;
  - at H_TOT-1 it wraps to 0 and sy advances.
- Vertical counter sy:
  - counts 0..V_TOT-1;
  - wraps to 0 when sx and sy are both at their maximum in the same cycle.
- Raw timing, decoded combinationally from the counters:
  - de_raw = (sx < H_RES) && (sy < V_RES);
  - hs_raw is active for sx in [H_RES+H_FP, H_RES+H_FP+H_SYNC-1], i.e. 656..751 by default;
  - vs_raw is active for sy in [V_RES+V_FP, V_RES+V_FP+V_SYNC-1], i.e. 490..491 by default, for every sx on those lines.
- line and frame are decoded from the current counters and are not delayed: they lead the aligned outputs by LAT+1 cycles.
- de_raw, hs_raw and vs_raw pass through a LAT-deep shift register, then one output register. With LAT=0 the shift register is bypassed.
- red/green/blue are registered from r_in/g_in/b_in when the delayed de is 1, and forced to 0 otherwise.
- Output syncs: hsync = active ? H_POL : ~H_POL; vsync = active ? V_POL : ~V_POL.
- The block has no handshake. The pixel source must present colour exactly LAT cycles after the coordinates, every cycle.

## Timing
- Reset (rst_pix=1 at a rising edge), on that edge:
  - sx = 0, sy = 0;
  - every delay-line stage is loaded with de=0 and syncs inactive;
  - red/green/blue = 0, de = 0, hsync = ~H_POL, vsync = ~V_POL.
- While reset is held, line and frame are 1, because the counters sit at 0,0.
- First cycle after reset release: sx=0, sy=0, frame=1, line=1. sx=1 follows on the next cycle.
- Reset mid-frame: the same as above, with no partial sync pulse emitted afterwards. The delay line is flushed, so the outputs stay inactive for LAT+1 cycles after release.
- Latency: coordinates at cycle t correspond to r_in at t+LAT. red/green/blue, de, hsync and vsync for that pixel are valid at t+LAT+1.
- Per frame (defaults): 420000 cycles, 525 line strobes, one frame strobe, 307200 de cycles.

## Test plan
- Default parameters, run 2 frames:
  - frame strobe period = 420000 cycles;
  - line strobe period = 800 cycles;
  - de high for 307200 cycles per frame, in runs of 640.
- Sync widths and levels:
  - hsync low for exactly 96 cycles per line, starting 16 cycles after de falls (aligned domain);
  - vsync low for exactly 1600 cycles, starting at line 490.
- Alignment check, LAT=2: the bench model drives r_in = sx[7:0] (from the coordinate issued LAT cycles earlier), g_in = sy[7:0] (likewise), b_in = 0xA5.
  - On the first de cycle of line 0: red=0, green=0, blue=0xA5;
  - at pixel 639 of line 479: red=0x7F, green=0xDF;
  - the colour outputs are 0 whenever de=0.
- LAT=0: the same alignment check passes with the outputs valid one cycle after the coordinates.
- Reset mid-frame: assert rst_pix for 3 cycles at sx=700, sy=300.
  - Outputs are inactive during reset and for LAT+1 cycles after release;
  - sx=0, sy=0, frame=1 on the first cycle after release.
- H_POL=1, V_POL=1, with a reduced 16x8 active area and 1/2/1 porches:
  - syncs are active-high with the correct widths;
  - counters wrap at the reduced totals with no off-by-one.
